// File: rtl/decode_sweep_pkg.sv
// Shared types and constants for the decoder sweep generator: FSM states,
// MISR polynomial/seed, phase-enable bit indices and the control-bus fold.
package decode_sweep_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P_FUNCT,
    S_P_RT,
    S_P_OP,
    S_DONE
  } state_t;

  localparam logic [31:0] SIG_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] SIG_SEED = 32'hFFFF_FFFF;

  localparam logic [1:0] PH_FUNCT = 2'd0;
  localparam logic [1:0] PH_RT    = 2'd1;
  localparam logic [1:0] PH_OP    = 2'd2;

  localparam int unsigned FOLD_OUT_W = 64;
  localparam int unsigned FOLD_IN_W  = 256;

  // XOR sig_w-wide chunks of a zero-extended bus into one sig_w-wide word
  function automatic logic [FOLD_OUT_W-1:0] fold(input logic [FOLD_IN_W-1:0] d,
                                                 input int unsigned        sig_w);
    logic [FOLD_OUT_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < FOLD_IN_W; i++) begin
      r[6'(i % sig_w)] ^= d[8'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/decode_sweep_gen_if.sv
// Decoder-side stimulus/response bus plus the trace record handshake.
interface decode_sweep_gen_if #(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned RT_W    = 5,
  parameter int unsigned CTL_W   = 35
);
  localparam int unsigned TR_W = OP_W + FUNCT_W + RT_W + CTL_W;

  logic [OP_W-1:0]    opcode;
  logic [FUNCT_W-1:0] funct;
  logic [RT_W-1:0]    rt;
  logic [CTL_W-1:0]   ctl_in;
  logic               trace_valid;
  logic               trace_ready;
  logic [TR_W-1:0]    trace_data;

  modport master (
    output opcode, funct, rt, trace_valid, trace_data,
    input  ctl_in, trace_ready
  );

  modport slave (
    input  opcode, funct, rt, trace_valid, trace_data,
    output ctl_in, trace_ready
  );
endinterface

// File: rtl/decode_sweep_gen_misr.sv
// Multiple-input signature register compressing the decoder control bus.
module sweep_misr
  import decode_sweep_pkg::*;
#(
  parameter int unsigned SIG_W = 32,
  parameter int unsigned CTL_W = 35
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [CTL_W-1:0] i_data,
  output logic [SIG_W-1:0] o_sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_next;

  always_comb begin
    w_next = {r_sig[SIG_W-2:0], 1'b0}
           ^ (r_sig[SIG_W-1] ? SIG_W'(SIG_POLY) : '0)
           ^ SIG_W'(fold(FOLD_IN_W'(i_data), SIG_W));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sig <= SIG_W'(SIG_SEED);
    end else if (i_clr) begin
      r_sig <= SIG_W'(SIG_SEED);
    end else if (i_en) begin
      r_sig <= w_next;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/decode_sweep_gen.sv
// Decoder field sweeper: walks SPECIAL/funct, REGIMM/rt and opcode phases and
// folds sampled control outputs into a MISR. Optional trace port: SWEEP_TRACE_EN.
module decode_sweep_gen
  import decode_sweep_pkg::*;
#(
  parameter int unsigned OP_W        = 6,
  parameter int unsigned FUNCT_W     = 6,
  parameter int unsigned RT_W        = 5,
  parameter int unsigned CTL_W       = 35,
  parameter int unsigned SIG_W       = 32,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned SPECIAL_OP  = 0,
  parameter int unsigned REGIMM_OP   = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic [2:0]       phase_en,
  output logic             busy,
  output logic             done,
  output logic [15:0]      vec_cnt,
  output logic [SIG_W-1:0] signature,
  decode_sweep_gen_if.master dec
);

  localparam int unsigned    DW_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned    TR_W    = OP_W + FUNCT_W + RT_W + CTL_W;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(HOLD_CYCLES - 1);
  localparam logic [OP_W:0]  SPEC_X  = (OP_W+1)'(SPECIAL_OP);
  localparam logic [OP_W:0]  REG_X   = (OP_W+1)'(REGIMM_OP);

  // Step past the two opcodes owned by the funct and rt phases
  function automatic logic [OP_W:0] skip_op(input logic [OP_W:0] v);
    logic [OP_W:0] r;
    r = v;
    for (int k = 0; k < 2; k++) begin
      if (r == SPEC_X || r == REG_X) r = r + (OP_W+1)'(1);
    end
    return r;
  endfunction

  function automatic state_t next_phase(input state_t cur, input logic [2:0] en);
    state_t ns;
    ns = S_DONE;
    if (cur != S_P_OP && en[PH_OP]) ns = S_P_OP;
    if ((cur == S_IDLE || cur == S_DONE || cur == S_P_FUNCT) && en[PH_RT]) ns = S_P_RT;
    if ((cur == S_IDLE || cur == S_DONE) && en[PH_FUNCT]) ns = S_P_FUNCT;
    return ns;
  endfunction

  function automatic logic [OP_W-1:0] entry_op(input state_t s);
    case (s)
      S_P_FUNCT: return OP_W'(SPECIAL_OP);
      S_P_RT:    return OP_W'(REGIMM_OP);
      S_P_OP:    return OP_W'(skip_op('0));
      default:   return '0;
    endcase
  endfunction

  state_t             r_state;
  logic [OP_W-1:0]    r_opcode;
  logic [FUNCT_W-1:0] r_funct;
  logic [RT_W-1:0]    r_rt;
  logic [DW_W-1:0]    r_dwell;
  logic [2:0]         r_phase_en;
  logic [15:0]        r_vec_cnt;
  logic               r_busy;
  logic               r_done;
`ifdef SWEEP_TRACE_EN
  logic               r_trace_valid;
  logic [TR_W-1:0]    r_trace_data;
  logic               r_sampled;
`endif

  logic          w_idle_like;
  logic          w_start_ok;
  logic          w_run;
  logic          w_last_dwell;
  logic          w_last_vec;
  logic          w_sample;
  logic          w_adv;
  logic [OP_W:0] w_op_inc;
  state_t        w_ns_start;
  state_t        w_ns_phase;

  always_comb begin
    w_idle_like  = (r_state == S_IDLE) || (r_state == S_DONE);
    w_start_ok   = start && !abort && w_idle_like;
    w_run        = !w_idle_like && !pause && !abort;
    w_last_dwell = (r_dwell == DW_LAST);
    w_op_inc     = skip_op({1'b0, r_opcode} + (OP_W+1)'(1));
    w_ns_start   = next_phase(S_IDLE, phase_en);
    w_ns_phase   = next_phase(r_state, r_phase_en);
    case (r_state)
      S_P_FUNCT: w_last_vec = &r_funct;
      S_P_RT:    w_last_vec = &r_rt;
      S_P_OP:    w_last_vec = w_op_inc[OP_W];
      default:   w_last_vec = 1'b0;
    endcase
`ifdef SWEEP_TRACE_EN
    // Sample once per vector, then hold the vector until the record is taken
    w_sample = w_run && w_last_dwell && !r_sampled;
    w_adv    = w_run && w_last_dwell && r_sampled && (!r_trace_valid || dec.trace_ready);
`else
    w_sample = w_run && w_last_dwell;
    w_adv    = w_sample;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_opcode      <= '0;
      r_funct       <= '0;
      r_rt          <= '0;
      r_dwell       <= '0;
      r_phase_en    <= '0;
      r_vec_cnt     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
`ifdef SWEEP_TRACE_EN
      r_trace_valid <= 1'b0;
      r_trace_data  <= '0;
      r_sampled     <= 1'b0;
`endif
    end else if (abort) begin
      r_state       <= S_IDLE;
      r_opcode      <= '0;
      r_funct       <= '0;
      r_rt          <= '0;
      r_dwell       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
`ifdef SWEEP_TRACE_EN
      r_trace_valid <= 1'b0;
      r_sampled     <= 1'b0;
`endif
    end else begin
`ifdef SWEEP_TRACE_EN
      if (r_trace_valid && dec.trace_ready) r_trace_valid <= 1'b0;
      if (w_sample) begin
        r_trace_valid <= 1'b1;
        r_trace_data  <= {r_opcode, r_funct, r_rt, dec.ctl_in};
        r_sampled     <= 1'b1;
      end
      if (w_adv) r_sampled <= 1'b0;
`endif
      if (w_start_ok) begin
        r_vec_cnt  <= '0;
        r_phase_en <= phase_en;
        r_state    <= w_ns_start;
        r_opcode   <= entry_op(w_ns_start);
        r_funct    <= '0;
        r_rt       <= '0;
        r_dwell    <= '0;
        r_busy     <= (w_ns_start != S_DONE);
        r_done     <= (w_ns_start == S_DONE);
      end
      if (w_sample && r_vec_cnt != 16'hFFFF) r_vec_cnt <= r_vec_cnt + 16'd1;
      if (w_adv) begin
        r_dwell <= '0;
        if (w_last_vec) begin
          r_state  <= w_ns_phase;
          r_opcode <= entry_op(w_ns_phase);
          r_funct  <= '0;
          r_rt     <= '0;
          if (w_ns_phase == S_DONE) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end else begin
          case (r_state)
            S_P_FUNCT: r_funct  <= r_funct + FUNCT_W'(1);
            S_P_RT:    r_rt     <= r_rt + RT_W'(1);
            S_P_OP:    r_opcode <= OP_W'(w_op_inc);
            default:   ;
          endcase
        end
      end else if (w_run && !w_last_dwell) begin
        r_dwell <= r_dwell + DW_W'(1);
      end
    end
  end

  sweep_misr #(
    .SIG_W (SIG_W),
    .CTL_W (CTL_W)
  ) u_misr (
    .clk    (clk),
    .resetn (resetn),
    .i_en   (w_sample),
    .i_clr  (w_start_ok),
    .i_data (dec.ctl_in),
    .o_sig  (signature)
  );

  assign dec.opcode = r_opcode;
  assign dec.funct  = r_funct;
  assign dec.rt     = r_rt;
  assign busy       = r_busy;
  assign done       = r_done;
  assign vec_cnt    = r_vec_cnt;

`ifdef SWEEP_TRACE_EN
  assign dec.trace_valid = r_trace_valid;
  assign dec.trace_data  = r_trace_data;
`else
  logic w_unused_trace_ready;
  assign w_unused_trace_ready = dec.trace_ready;
  assign dec.trace_valid      = 1'b0;
  assign dec.trace_data       = '0;
`endif

endmodule

// File: doc/decode_sweep_gen.md
Name: decode_sweep_gen

Overview:
- Synthesizable stimulus sequencer and signature collector for the control decoder.
- Walks the instruction-field space for a configurable set of phases:
  - SPECIAL opcode with every funct,
  - REGIMM opcode with every rt,
  - every remaining opcode.
- Drives opcode/funct/rt into the decoder, samples its packed control outputs once per vector and compresses them into a MISR signature.
- Field widths, dwell time and phase selection are parametrised; replaces open-loop bench sweeps for on-board and regression self-check.

Parameters:
- OP_W, 6, opcode field width.
- FUNCT_W, 6, funct field width.
- RT_W, 5, rt field width.
- CTL_W, 35, width of packed decoder control bus (pcValue..temp_wen, MSB first).
- SIG_W, 32, MISR width.
- HOLD_CYCLES, 2, cycles each vector is held (>=1).
- SPECIAL_OP, 0, opcode swept with funct.
- REGIMM_OP, 1, opcode swept with rt.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  pulse: begin sweep (ignored unless IDLE or DONE)
- abort  in  1  return to IDLE immediately
- pause  in  1  freeze sequencer (hold counters and fields)
- phase_en  in  3  bit0 funct phase, bit1 rt phase, bit2 opcode phase
- ctl_in  in  CTL_W  decoder control outputs
- opcode  out  OP_W  driven opcode
- funct  out  FUNCT_W  driven funct
- rt  out  RT_W  driven rt
- busy  out  1  sweep in progress
- done  out  1  sweep complete (level, cleared by start/abort)
- vec_cnt  out  16  vectors sampled this sweep
- signature  out  SIG_W  MISR value
- trace_valid  out  1  trace record valid
- trace_ready  in  1  trace consumer ready
- trace_data  out  OP_W+FUNCT_W+RT_W+CTL_W  {opcode,funct,rt,ctl_in}

Behaviour:
- Reset values:
  - opcode, funct, rt, vec_cnt = 0; busy = done = trace_valid = 0.
  - signature = SIG_SEED.
  - State = IDLE.
  - Reset mid-sweep discards everything.
- States: IDLE, P_FUNCT, P_RT, P_OP, DONE.
- start in IDLE/DONE:
  - Clear vec_cnt, load SIG_SEED, clear done.
  - Next cycle enters first enabled phase in order FUNCT, RT, OP; busy=1 from that cycle.
  - phase_en==0 -> go straight to DONE, vec_cnt=0.
- Field values driven during each phase:
  - P_FUNCT: opcode=SPECIAL_OP, rt=0, funct 0..2^FUNCT_W-1.
  - P_RT: opcode=REGIMM_OP, funct=0, rt 0..2^RT_W-1.
  - P_OP: funct=rt=0, opcode 0..2^OP_W-1, skipping SPECIAL_OP and REGIMM_OP.
- Per-vector timing:
  - Dwell counter counts HOLD_CYCLES cycles.
  - On the last dwell cycle, ctl_in is sampled, the MISR updates and vec_cnt increments.
  - The next vector is driven in the following cycle.
- MISR update: sig' = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : 0) ^ fold(ctl_in).
  - fold zero-extends ctl_in to a multiple of SIG_W and XORs the chunks.
- Phase end: after the last value of a phase, go to the next enabled phase, else DONE.
- DONE: busy=0, done=1; fields return to 0; signature and vec_cnt held.
- pause: freezes the dwell counter, field counters, MISR and FSM. It does not block abort or reset.
- abort: from any state, go to IDLE next cycle with busy=0, done=0, fields=0. signature and vec_cnt keep their partial values.
- Simultaneous events:
  - abort beats start.
  - start while busy is ignored.
  - pause with start in IDLE: start is accepted, then the sequencer is frozen in the first phase.
- vec_cnt saturates at 16'hFFFF.

Optional Feature:
- Macro SWEEP_TRACE_EN.
- With the macro defined:
  - On each sample cycle, trace_valid=1 and trace_data is captured.
  - The sequencer stalls (as pause) until trace_valid && trace_ready.
  - MISR and vec_cnt update once, at the sample.
  - trace_data is stable while valid.
- Without the macro: trace_valid=0, trace_data=0, trace_ready ignored, no stall.

Decomposition:
- Package decode_sweep_pkg holds:
  - state enum,
  - SIG_POLY = 32'h04C1_1DB7,
  - SIG_SEED = 32'hFFFF_FFFF,
  - the fold function,
  - phase_en bit index constants.
- One sub-module: sweep_misr (SIG_W, CTL_W; enable, clear-to-seed, data in, signature out).

Test Plan:
- phase_en=3'b111, HOLD_CYCLES=2, defaults, start -> vec_cnt=158 (64+32+62), done=1, busy=0; opcode sequence skips 0 and 1 in P_OP; signature matches the bench reference model.
- phase_en=3'b010 -> only rt 0..31 with opcode=1, vec_cnt=32; each value held exactly 2 cycles.
- pause asserted 10 cycles mid P_FUNCT at funct=5 -> funct stays 5, signature unchanged; resumes and final signature equals the unpaused run.
- abort at vec_cnt=40 -> IDLE next cycle, done=0, vec_cnt=40; restart gives vec_cnt=158 and a fresh signature.
- resetn pulsed low mid P_OP -> all outputs at reset values asynchronously, signature=32'hFFFF_FFFF.
- SWEEP_TRACE_EN, trace_ready low for 5 cycles at vector 3 -> trace_valid held with trace_data stable and the sequencer stalled; final vec_cnt=158.
